// File: rtl/div_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// div_pkg : shared state encoding, error codes and width default.
// Rev 1.0
// ------------------------------------------------------------------
package div_pkg;

    localparam int DIV_DATA_W = 8;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OVF  = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_Q   = 3'd2,
        ST_SEND_M   = 3'd3,
        ST_WAIT_FIN = 3'd4,
        ST_CAP_R    = 3'd5,
        ST_CAP_Q    = 3'd6,
        ST_RESP     = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_watchdog.sv
`default_nettype none
// ------------------------------------------------------------------
// div_watchdog : cycle counter for WAIT_FIN, expires at TIMEOUT-1.
// Rev 1.0
// ------------------------------------------------------------------
module div_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && (count_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/div_req_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// div_req_sequencer : screens, serialises and collects requests for
// the 8-bit non-restoring divider.  Rev 1.0
// ------------------------------------------------------------------
module div_req_sequencer
    import div_pkg::*;
#(
    parameter int DATA_W  = DIV_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2*DATA_W-1:0]   req_dividend,
    input  logic [DATA_W-1:0]     req_divisor,
    output logic                  div_begin,
    output logic [DATA_W-1:0]     div_in_bus,
    input  logic                  div_fin,
    input  logic [DATA_W-1:0]     div_out_bus,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_quotient,
    output logic [DATA_W-1:0]     rsp_remainder,
    output logic [1:0]            rsp_err,
    output logic                  busy
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [DATA_W-1:0]  m_q, m_d;
    logic [DATA_W-1:0]  quo_q, quo_d;
    logic [DATA_W-1:0]  rem_q, rem_d;
    logic [1:0]         err_q, err_d;
    logic               wd_expire;

    div_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_WAIT_FIN),
        .enable (state_q == ST_WAIT_FIN),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d = req_dividend[2*DATA_W-1:DATA_W];
                    q_d = req_dividend[DATA_W-1:0];
                    m_d = req_divisor;
                    if (req_divisor == '0) begin
                        state_d = ST_RESP;
                        err_d   = ERR_DIV0;
                        quo_d   = '1;
                        rem_d   = req_dividend[DATA_W-1:0];
                    end else if (req_dividend[2*DATA_W-1:DATA_W] >= req_divisor) begin
                        // Upper half >= divisor means the quotient cannot fit in DATA_W bits.
                        state_d = ST_RESP;
                        err_d   = ERR_OVF;
                        quo_d   = '1;
                        rem_d   = req_dividend[DATA_W-1:0];
                    end else begin
                        state_d = ST_SEND_A;
                    end
                end
            end
            ST_SEND_A: state_d = ST_SEND_Q;
            ST_SEND_Q: state_d = ST_SEND_M;
            ST_SEND_M: state_d = ST_WAIT_FIN;
            ST_WAIT_FIN: begin
                if (div_fin) begin
                    state_d = ST_CAP_R;
                end else if (wd_expire) begin
                    state_d = ST_RESP;
                    err_d   = ERR_TMO;
                    quo_d   = '0;
                    rem_d   = '0;
                end
            end
            ST_CAP_R: begin
                rem_d   = div_out_bus;
                state_d = ST_CAP_Q;
            end
            ST_CAP_Q: begin
                quo_d   = div_out_bus;
                err_d   = ERR_OK;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Operand byte is selected purely by state from registered operands.
    always_comb begin
        div_in_bus = '0;
        case (state_q)
            ST_SEND_A: div_in_bus = a_q;
            ST_SEND_Q: div_in_bus = q_q;
            ST_SEND_M: div_in_bus = m_q;
            default:   div_in_bus = '0;
        endcase
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign div_begin     = (state_q == ST_SEND_A);
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_req_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_div_req_sequencer : vector table plus corner sequences against a
// behavioural divider model and a response scoreboard.  Rev 1.0
// ------------------------------------------------------------------
module tb_div_req_sequencer;
    import div_pkg::*;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_dividend = '0;
    logic [7:0]  req_divisor = '0;
    logic        div_begin;
    logic [7:0]  div_in_bus;
    logic        div_fin = 1'b0;
    logic [7:0]  div_out_bus = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_quotient;
    logic [7:0]  rsp_remainder;
    logic [1:0]  rsp_err;
    logic        busy;

    always #5 clk = ~clk;

    div_req_sequencer #(
        .DATA_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .div_begin     (div_begin),
        .div_in_bus    (div_in_bus),
        .div_fin       (div_fin),
        .div_out_bus   (div_out_bus),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    typedef struct packed {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic [1:0]  err;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   sb_begin[$];
    exp_t tbl[10];

    // behavioural divider state
    int       mph = 0;
    int       mcnt = 0;
    int       lat = 20;
    bit       never_fin = 1'b0;
    logic [7:0] cap_a = '0, cap_q = '0, cap_m = '0;
    int       begin_cnt = 0;
    int       extra_begin = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [15:0] num;
        if (div_begin) begin_cnt++;
        case (mph)
            0: if (div_begin) begin cap_a = div_in_bus; mph = 1; end
            1: begin cap_q = div_in_bus; if (div_begin) extra_begin++; mph = 2; end
            2: begin cap_m = div_in_bus; if (div_begin) extra_begin++; mcnt = lat; mph = 3; end
            3: begin
                if (!never_fin) begin
                    mcnt--;
                    if (mcnt == 0) begin div_fin = 1'b1; mph = 4; end
                end
            end
            4: begin
                num = {cap_a, cap_q};
                div_fin = 1'b0;
                div_out_bus = (cap_m == 0) ? 8'h00 : 8'(num % {8'h00, cap_m});
                mph = 5;
            end
            5: begin
                num = {cap_a, cap_q};
                div_out_bus = (cap_m == 0) ? 8'h00 : 8'(num / {8'h00, cap_m});
                mph = 6;
            end
            default: begin div_out_bus = 8'h00; mph = 0; end
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic send_req(input exp_t e);
        int w = 0;
        while (!req_ready && w < 200) begin tick(); w++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_dividend = e.dd;
        req_divisor  = e.dv;
        sb.push_back(e);
        sb_begin.push_back(begin_cnt);
    endtask

    task automatic wait_rsp(input int exp_lat, input bit bp);
        int   n = 0;
        exp_t e;
        int   b0;
        logic [17:0] snap;
        rsp_ready = !bp;
        do begin
            tick();
            req_valid = 1'b0;
            n++;
        end while (!rsp_valid && n < 300);
        chk("rsp_latency", n, exp_lat);
        if (bp) begin
            snap = {rsp_quotient, rsp_remainder, rsp_err};
            repeat (5) begin
                tick();
                chk("bp_hold", {rsp_valid, req_ready, rsp_quotient, rsp_remainder, rsp_err},
                    {1'b1, 1'b0, snap});
            end
            rsp_ready = 1'b1;
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e  = sb.pop_front();
            b0 = sb_begin.pop_front();
            chk("rsp_quotient", rsp_quotient, e.q);
            chk("rsp_remainder", rsp_remainder, e.r);
            chk("rsp_err", rsp_err, e.err);
            chk("begin_count", begin_cnt - b0,
                (e.err == ERR_OK || e.err == ERR_TMO) ? 32'd1 : 32'd0);
            if (e.err == ERR_OK || e.err == ERR_TMO)
                chk("bus_bytes", {cap_a, cap_q, cap_m}, {e.dd, e.dv});
        end
        tick();
        chk("rsp_drop", {rsp_valid, req_ready, busy}, 3'b010);
    endtask

    initial begin
        tbl[0] = '{16'h03E8, 8'h07, 8'h8E, 8'h06, ERR_OK};
        tbl[1] = '{16'h1234, 8'h00, 8'hFF, 8'h34, ERR_DIV0};
        tbl[2] = '{16'h0800, 8'h08, 8'hFF, 8'h00, ERR_OVF};
        tbl[3] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, ERR_OK};
        tbl[4] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, ERR_OK};
        tbl[5] = '{16'h07FF, 8'h08, 8'hFF, 8'h07, ERR_OK};
        tbl[6] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, ERR_OK};
        tbl[7] = '{16'hFF00, 8'hFF, 8'hFF, 8'h00, ERR_OVF};
        tbl[8] = '{16'h0005, 8'h03, 8'h01, 8'h02, ERR_OK};
        tbl[9] = '{16'h0100, 8'h01, 8'hFF, 8'h00, ERR_OVF};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outputs", {rsp_valid, div_begin, div_in_bus, rsp_quotient, rsp_remainder, rsp_err, busy}, 32'd0);
        rst = 1'b1;
        tick();

        // fin while idle must be ignored
        div_fin = 1'b1;
        tick();
        div_fin = 1'b0;
        tick();
        chk("fin_idle_ignored", {req_ready, busy}, 2'b10);

        lat = 20;
        for (int i = 0; i < 10; i++) begin
            send_req(tbl[i]);
            wait_rsp((tbl[i].err == ERR_OK) ? lat + 6 : 1, i == 3);
        end

        // divider never finishes: timeout 64 cycles after entering WAIT_FIN
        never_fin = 1'b1;
        send_req('{16'h03E8, 8'h07, 8'h00, 8'h00, ERR_TMO});
        wait_rsp(4 + TMO, 1'b0);
        never_fin = 1'b0;
        mph = 0;

        // fin lands on the watchdog expiry cycle
        lat = TMO;
        send_req('{16'h03E8, 8'h07, 8'h8E, 8'h06, ERR_OK});
        wait_rsp(TMO + 6, 1'b0);
        lat = 20;

        // reset while waiting for the divider
        never_fin = 1'b1;
        send_req('{16'h03E8, 8'h07, 8'h00, 8'h00, ERR_TMO});
        repeat (10) begin tick(); req_valid = 1'b0; end
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("reset_async", {rsp_valid, req_ready, busy, div_begin}, 4'b0100);
        sb.delete();
        sb_begin.delete();
        mph = 0;
        never_fin = 1'b0;
        div_fin = 1'b0;
        div_out_bus = 8'h00;
        tick();
        rst = 1'b1;
        tick();
        send_req('{16'h0064, 8'h0A, 8'h0A, 8'h00, ERR_OK});
        wait_rsp(lat + 6, 1'b0);

        chk("extra_begin", extra_begin, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_req_sequencer.md
Name: div_req_sequencer

Overview:
- Upstream/downstream adapter for the 8-bit non-restoring divider.
- Accepts a parallel 16-bit dividend / 8-bit divisor request over a valid/ready handshake.
- Screens out illegal operands, serialises legal ones onto the divider's shared 8-bit input bus with a begin strobe, and collects remainder and quotient from the divider's output bus.
- Returns the result over a valid/ready response handshake with an error code.

Parameters:
- DATA_W, 8, divider byte width; dividend is 2*DATA_W.
- TIMEOUT, 64, max cycles in WAIT_FIN before a timeout error; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; shared with the divider.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_dividend  in  16  dividend; [15:8] loads A, [7:0] loads Q.
- req_divisor  in  8  divisor; loads M.
- div_begin  out  1  begin strobe to divider.
- div_in_bus  out  8  operand byte to divider.
- div_fin  in  1  divider finished.
- div_out_bus  in  8  divider result byte.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_quotient  out  8  quotient.
- rsp_remainder  out  8  remainder.
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE; watchdog counter cleared.
  - Outputs: req_ready=1, rsp_valid=0, div_begin=0, div_in_bus=0, rsp_* data=0, rsp_err=00, busy=0.
- States: IDLE, SEND_A, SEND_Q, SEND_M, WAIT_FIN, CAP_R, CAP_Q, RESP.
- IDLE:
  - On req_valid&&req_ready, latch the operands.
  - divisor==0: go to RESP with err=01, quotient=FF, remainder=dividend[7:0].
  - Else dividend[15:8] >= divisor: go to RESP with err=10, quotient=FF, remainder=dividend[7:0].
  - Else go to SEND_A.
  - Error responses are therefore valid in the cycle after accept; the divider is not touched.
- SEND_A (1 cycle): div_begin=1, div_in_bus=dividend[15:8].
- SEND_Q (1 cycle): div_begin=0, div_in_bus=dividend[7:0].
- SEND_M (1 cycle): div_in_bus=divisor.
- In all other states div_in_bus=0 and div_begin=0.
- WAIT_FIN:
  - Watchdog counts from 0 each cycle.
  - div_fin=1 goes to CAP_R.
  - Watchdog reaching TIMEOUT-1 without fin goes to RESP with err=11, quotient=00, remainder=00.
  - fin in the same cycle as expiry: fin wins.
- CAP_R: register div_out_bus into rsp_remainder.
- CAP_Q: register div_out_bus into rsp_quotient; go to RESP with err=00.
- Divider contract: result bytes appear on the first and second cycles after fin is sampled high (remainder, then quotient).
- RESP:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0.
  - On rsp_ready go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the same cycle.
- Latency, legal request: accept at cycle 0, SEND_A at 1, SEND_M at 3, WAIT_FIN from 4. rsp_valid = fin cycle + 3.
- div_fin outside WAIT_FIN is ignored.
- Reset asserted mid-operation:
  - Immediate return to IDLE; in-flight request is discarded with no response.
  - Divider is reset by the same rst.
- All outputs are registered or decoded from the state register only; no combinational path from req_* or div_fin to outputs.

Decomposition:
- Shared package div_pkg holds:
  - state enum;
  - err code constants ERR_OK/ERR_DIV0/ERR_OVF/ERR_TMO;
  - DATA_W default.
- One sub-module: div_watchdog (clear, enable, count, expire at TIMEOUT-1).

Test Plan:
- Normal: dividend 0x03E8, divisor 0x07, behavioural divider model with 20-cycle latency -> bus sequence 03,E8,07 with begin only on first; rsp quotient 0x8E, remainder 0x06, err 00.
- Divide-by-zero: 0x1234 / 0x00 -> rsp_valid one cycle after accept, err 01, quotient FF, remainder 34, div_begin never asserted.
- Overflow: 0x0800 / 0x08 -> err 10, quotient FF, remainder 00, no divider activity.
- Timeout: model never asserts fin -> err 11 exactly TIMEOUT=64 cycles after entering WAIT_FIN; fin pulsed on the expiry cycle in a second run -> normal completion.
- Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready=0 throughout; back-to-back requests complete in order.
- Reset in WAIT_FIN: rst low for 1 cycle -> immediate IDLE, rsp_valid=0, req_ready=1; next request 0x0064/0x0A -> quotient 0x0A, remainder 0x00.
